// File: rtl/amb_seq_pkg.sv
// Shared types and constants for the amb_seq command sequencer.
// Ops, FSM states, data width and a saturating increment helper.
package amb_seq_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_CMP     = 2'b10,
    OP_ILL_ACC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + DATA_W'(1);
  endfunction

endpackage

// File: rtl/amb_seq_if.sv
// Command/response bus of amb_seq. Both channels use valid/ready: a transfer
// happens on a rising edge where valid and ready are both high; valid is
// held with stable payload until that edge.
interface amb_seq_if;

  logic                                cmd_valid;
  logic                                cmd_ready;
  logic [1:0]                          cmd_op;
  logic [amb_seq_pkg::DATA_W-1:0]      cmd_a;
  logic [amb_seq_pkg::DATA_W-1:0]      cmd_b;
  logic                                rsp_valid;
  logic                                rsp_ready;
  logic [amb_seq_pkg::DATA_W-1:0]      rsp_result;
  logic                                rsp_eq;
  logic                                rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_eq, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_eq, rsp_err
  );

endinterface

// File: rtl/amb_seq.sv
// Sequences ADD/SUB/CMP commands through an external adder/subtractor.
// Optional build macro AMB_SEQ_ACC_EN turns op 11 into ACC (accumulate cmd_b).
module amb_seq
  import amb_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  amb_seq_if.slave          bus,
  output logic              amb_op,
  output logic [DATA_W-1:0] amb_operand1,
  output logic [DATA_W-1:0] amb_operand2,
  input  logic [DATA_W-1:0] amb_result,
  input  logic              amb_isEqual,
  output logic [DATA_W-1:0] ops_done,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              amb_op_q, amb_op_d;
  logic [DATA_W-1:0] operand1_q, operand1_d;
  logic [DATA_W-1:0] operand2_q, operand2_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_eq_q, rsp_eq_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] ops_done_q, ops_done_d;
`ifdef AMB_SEQ_ACC_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  logic cmd_hs;
  logic rsp_hs;
  logic cmd_legal;

  assign cmd_hs = bus.cmd_valid && bus.cmd_ready;
  assign rsp_hs = bus.rsp_valid && bus.rsp_ready;
`ifdef AMB_SEQ_ACC_EN
  assign cmd_legal = 1'b1;
`else
  assign cmd_legal = (bus.cmd_op != OP_ILL_ACC);
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_hs) state_d = cmd_legal ? ST_EXEC : ST_RESP;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs; cmd_ready stays low while reset is held so every output is 0
  always_comb begin
    bus.cmd_ready = (state_q == ST_IDLE) && !rst;
    bus.rsp_valid = (state_q == ST_RESP);
    dbg_state     = state_q;
  end

  // Datapath: operands only move on a legal accept, so the AMB port is quiet otherwise
  always_comb begin
    op_d         = op_q;
    amb_op_d     = amb_op_q;
    operand1_d   = operand1_q;
    operand2_d   = operand2_q;
    rsp_result_d = rsp_result_q;
    rsp_eq_d     = rsp_eq_q;
    rsp_err_d    = rsp_err_q;
    ops_done_d   = ops_done_q;
`ifdef AMB_SEQ_ACC_EN
    acc_d        = acc_q;
`endif
    if (cmd_hs) begin
      op_d = op_e'(bus.cmd_op);
      if (cmd_legal) begin
        amb_op_d   = (bus.cmd_op == OP_SUB) || (bus.cmd_op == OP_CMP);
        operand1_d = bus.cmd_a;
        operand2_d = bus.cmd_b;
`ifdef AMB_SEQ_ACC_EN
        if (bus.cmd_op == OP_ILL_ACC) operand1_d = acc_q;
`endif
      end else begin
        rsp_result_d = '0;
        rsp_eq_d     = 1'b0;
        rsp_err_d    = 1'b1;
      end
    end
    if (state_q == ST_EXEC) begin
      rsp_result_d = (op_q == OP_CMP) ? '0 : amb_result;
      rsp_eq_d     = amb_isEqual;
      rsp_err_d    = 1'b0;
`ifdef AMB_SEQ_ACC_EN
      if (op_q != OP_CMP) acc_d = amb_result;
`endif
    end
    if (rsp_hs && !rsp_err_q) ops_done_d = sat_inc(ops_done_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= OP_ADD;
      amb_op_q     <= 1'b0;
      operand1_q   <= '0;
      operand2_q   <= '0;
      rsp_result_q <= '0;
      rsp_eq_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= '0;
`ifdef AMB_SEQ_ACC_EN
      acc_q        <= '0;
`endif
    end else begin
      op_q         <= op_d;
      amb_op_q     <= amb_op_d;
      operand1_q   <= operand1_d;
      operand2_q   <= operand2_d;
      rsp_result_q <= rsp_result_d;
      rsp_eq_q     <= rsp_eq_d;
      rsp_err_q    <= rsp_err_d;
      ops_done_q   <= ops_done_d;
`ifdef AMB_SEQ_ACC_EN
      acc_q        <= acc_d;
`endif
    end
  end

  assign amb_op         = amb_op_q;
  assign amb_operand1   = operand1_q;
  assign amb_operand2   = operand2_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_eq     = rsp_eq_q;
  assign bus.rsp_err    = rsp_err_q;
  assign ops_done       = ops_done_q;

endmodule

// File: tb/tb_amb_seq.sv
// Randomised bench for amb_seq with a behavioural adder beside it and an
// arithmetic reference model. Honours AMB_SEQ_ACC_EN when defined.
module tb_amb_seq;
  import amb_seq_pkg::*;

  localparam int W = DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  amb_seq_if bus();

  logic         amb_op;
  logic [W-1:0] amb_operand1, amb_operand2, amb_result, ops_done;
  logic         amb_isEqual;
  state_e       dbg_state;

  amb_seq dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .amb_op       (amb_op),
    .amb_operand1 (amb_operand1),
    .amb_operand2 (amb_operand2),
    .amb_result   (amb_result),
    .amb_isEqual  (amb_isEqual),
    .ops_done     (ops_done),
    .dbg_state    (dbg_state)
  );

  // adder/subtractor sitting next to the sequencer
  assign amb_result  = amb_op ? amb_operand1 - amb_operand2 : amb_operand1 + amb_operand2;
  assign amb_isEqual = (amb_operand1 == amb_operand2);

  // scoreboard
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  int           model_ops = 0;
  int           model_acc = 0;
  int           prev_op = 0, prev_o1 = 0, prev_o2 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: what one command should produce
  task automatic model_cmd(input int op, input int a, input int b,
                           output int res, output int eq, output int err, output int lat,
                           output int xop, output int x1, output int x2);
    err = 0; lat = 2; x1 = a; x2 = b; xop = 0; res = 0;
    case (op)
      0: res = (a + b) % 65536;
      1: begin res = (a - b + 65536) % 65536; xop = 1; end
      2: begin res = 0; xop = 1; end
      default: begin
`ifdef AMB_SEQ_ACC_EN
        x1  = model_acc;
        res = (model_acc + b) % 65536;
`else
        err = 1; lat = 1; res = 0;
        xop = prev_op; x1 = prev_o1; x2 = prev_o2;
`endif
      end
    endcase
    eq = (err == 0 && x1 == x2) ? 1 : 0;
`ifdef AMB_SEQ_ACC_EN
    if (op != 2) model_acc = res;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_result"}, bus.rsp_result, 0);
    check({tag, "_rsp_eq"}, bus.rsp_eq, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
    check({tag, "_amb_op"}, amb_op, 0);
    check({tag, "_amb_operand1"}, amb_operand1, 0);
    check({tag, "_amb_operand2"}, amb_operand2, 0);
    check({tag, "_ops_done"}, ops_done, 0);
  endtask

  task automatic accept_cmd(input int op, input int a, input int b);
    int w = 0;
    bus.cmd_op    = op[1:0];
    bus.cmd_a     = a[W-1:0];
    bus.cmd_b     = b[W-1:0];
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && w < 20) begin step(); w++; end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom_range(0, 3));
    bus.cmd_a     = W'($urandom_range(0, 65535));
    bus.cmd_b     = W'($urandom_range(0, 65535));
  endtask

  // driver + checker for one complete transaction
  task automatic run_cmd(input int op, input int a, input int b, input int hold);
    int res, eq, err, lat_exp, xop, x1, x2, lat;
    logic [W-1:0] exp_r;
    model_cmd(op, a, b, res, eq, err, lat_exp, xop, x1, x2);
    exp_q.push_back(res[W-1:0]);
    accept_cmd(op, a, b);
    lat = 1;
    check("amb_op_exec", amb_op, xop);
    check("amb_operand1_exec", amb_operand1, x1);
    check("amb_operand2_exec", amb_operand2, x2);
    while (!bus.rsp_valid && lat < 8) begin step(); lat++; end
    check("rsp_latency", lat, lat_exp);
    exp_r = exp_q.pop_front();
    check("rsp_result", bus.rsp_result, exp_r);
    check("rsp_eq", bus.rsp_eq, eq);
    check("rsp_err", bus.rsp_err, err);
    check("cmd_ready_resp", bus.cmd_ready, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_rsp_result", bus.rsp_result, exp_r);
      check("hold_rsp_eq", bus.rsp_eq, eq);
      check("hold_cmd_ready", bus.cmd_ready, 0);
      check("hold_amb_operand1", amb_operand1, x1);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    if (err == 0 && model_ops < 65535) model_ops++;
    check("ops_done", ops_done, model_ops);
    check("rsp_valid_clear", bus.rsp_valid, 0);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    check("idle_amb_operand2", amb_operand2, x2);
    prev_op = xop; prev_o1 = x1; prev_o2 = x2;
  endtask

  // reset while a command is in EXEC (in_resp=0) or stalled in RESP (in_resp=1)
  task automatic reset_in_flight(input int in_resp, input int hold);
    int a = $urandom_range(0, 65535);
    int b = $urandom_range(0, 65535);
    accept_cmd(0, a, b);
    if (in_resp != 0) begin
      step();
      for (int i = 0; i < hold; i++) begin
        check("stall_rsp_valid", bus.rsp_valid, 1);
        check("stall_rsp_result", bus.rsp_result, (a + b) % 65536);
        check("stall_cmd_ready", bus.cmd_ready, 0);
        step();
      end
    end
    rst = 1'b1;
    step();
    check_all_zero("rst_flight");
    rst = 1'b0;
    #1;
    check("rst_flight_cmd_ready", bus.cmd_ready, 1);
    model_ops = 0; model_acc = 0; prev_op = 0; prev_o1 = 0; prev_o2 = 0;
    exp_q.delete();
    step();
    step();
    check("rst_flight_no_rsp", bus.rsp_valid, 0);
  endtask

  function automatic int pick_val();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 65535;
      2:       return $urandom_range(0, 15);
      default: return $urandom_range(0, 65535);
    endcase
  endfunction

  initial begin
    int a, b;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    step(); step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    check("reset_cmd_ready", bus.cmd_ready, 1);

`ifdef AMB_SEQ_ACC_EN
    run_cmd(3, 0, 5, 0);
    run_cmd(3, 0, 5, 1);
    run_cmd(3, 0, 5, 0);
    check("acc_ops_done_3", ops_done, 3);
`else
    run_cmd(0, 16'h1234, 16'h0011, 0);
    check("add_ops_done_1", ops_done, 1);
    run_cmd(1, 16'h0000, 16'h0001, 1);
    run_cmd(2, 16'hBEEF, 16'hBEEF, 0);
    run_cmd(2, 16'hBEEF, 16'hBEEE, 2);
    run_cmd(3, 16'h1111, 16'h2222, 0);
    check("illegal_ops_unchanged", ops_done, 4);
`endif
    run_cmd(0, 16'hFFFF, 16'h0001, 0);

    reset_in_flight(1, 5);
    reset_in_flight(0, 0);

    for (int n = 0; n < 200; n++) begin
      a = pick_val();
      b = ($urandom_range(0, 3) == 0) ? a : pick_val();
      if ($urandom_range(0, 39) == 0) reset_in_flight($urandom_range(0, 1), $urandom_range(1, 3));
      else run_cmd($urandom_range(0, 3), a, b, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
